// File: rtl/rsa_mem_slave.sv
// 256-bit Avalon-MM line memory feeding the RSA core, with programmable waitrequest
// stall, fixed read latency and a 32-bit host lane-write port for preloading lines.
module rsa_mem_slave #(
   parameter int DEPTH       = 40,
   parameter int WAIT_CYCLES = 3,
   parameter int READ_LAT    = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [31:0]  avs_s0_address,
   input  logic         avs_s0_read,
   input  logic         avs_s0_write,
   input  logic [255:0] avs_s0_writedata,
   output logic         avs_s0_waitrequest,
   output logic [255:0] avs_s0_readdata,
   output logic         avs_s0_readdatavalid,
   input  logic         host_wr_valid,
   output logic         host_wr_ready,
   input  logic [15:0]  host_wr_addr,
   input  logic [31:0]  host_wr_data,
   output logic         err_oob,
   output logic [15:0]  rd_count,
   output logic [15:0]  wr_count
);

   localparam int AW = $clog2(DEPTH);

   // Handshake: an Avalon command is taken in the cycle where (read|write) is high and
   // waitrequest is low; a host word is taken in the cycle where valid && ready.
   typedef enum logic [1:0] {IDLE, STALL, ACCEPT} state_t;

   state_t        r_state, w_state_nxt;
   logic [3:0]    r_cnt, w_cnt_nxt;
   logic          w_req, w_acc, w_rd_acc, w_wr_acc, w_host_acc;
   logic [26:0]   w_av_line;
   logic          w_av_oob;
   logic [AW-1:0] w_av_idx;
   logic [12:0]   w_host_line;
   logic          w_host_oob;
   logic [AW-1:0] w_host_idx;
   logic [7:0]    w_lane_lsb;
   logic [255:0]  w_rd_line;
   logic          w_unused_addr;

   logic [255:0]  r_mem [DEPTH];
   logic          r_pipe_vld [READ_LAT];
   logic [255:0]  r_pipe_dat [READ_LAT];
   logic          r_err_oob;
   logic [15:0]   r_rd_count, r_wr_count;

   assign w_req         = avs_s0_read | avs_s0_write;
   assign w_unused_addr = ^avs_s0_address[4:0];
   assign w_av_line     = avs_s0_address[31:5];
   assign w_av_oob      = (w_av_line >= 27'(DEPTH));
   assign w_av_idx      = w_av_line[AW-1:0];
   assign w_host_line   = host_wr_addr[15:3];
   assign w_host_oob    = (w_host_line >= 13'(DEPTH));
   assign w_host_idx    = w_host_line[AW-1:0];
   assign w_lane_lsb    = {host_wr_addr[2:0], 5'd0};
   assign w_rd_line     = w_av_oob ? '0 : r_mem[w_av_idx];

   // The IDLE cycle that first sees the request already counts as one stall cycle.
   always_comb begin
      w_state_nxt        = r_state;
      w_cnt_nxt          = r_cnt;
      avs_s0_waitrequest = 1'b0;
      w_acc              = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_req) begin
               if (WAIT_CYCLES == 0) begin
                  w_acc = 1'b1;
               end else begin
                  avs_s0_waitrequest = 1'b1;
                  w_cnt_nxt          = 4'(WAIT_CYCLES - 1);
                  w_state_nxt        = (WAIT_CYCLES == 1) ? ACCEPT : STALL;
               end
            end
         end
         STALL: begin
            avs_s0_waitrequest = 1'b1;
            if (!w_req) begin
               w_state_nxt = IDLE;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
               if (r_cnt <= 4'd1) w_state_nxt = ACCEPT;
            end
         end
         ACCEPT: begin
            w_acc       = w_req;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
      if (!reset) w_acc = 1'b0;
   end

   assign w_rd_acc      = w_acc & avs_s0_read;
   assign w_wr_acc      = w_acc & ~avs_s0_read & avs_s0_write;
   assign host_wr_ready = ~w_wr_acc;
   assign w_host_acc    = host_wr_valid & host_wr_ready & reset;

   always_ff @(posedge clk) begin
      if (w_wr_acc && !w_av_oob) r_mem[w_av_idx] <= avs_s0_writedata;
      if (w_host_acc && !w_host_oob) r_mem[w_host_idx][w_lane_lsb +: 32] <= host_wr_data;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_cnt      <= 4'd0;
         r_err_oob  <= 1'b0;
         r_rd_count <= 16'd0;
         r_wr_count <= 16'd0;
         for (int k = 0; k < READ_LAT; k++) begin
            r_pipe_vld[k] <= 1'b0;
            r_pipe_dat[k] <= '0;
         end
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_rd_acc) r_rd_count <= r_rd_count + 16'd1;
         if (w_wr_acc) r_wr_count <= r_wr_count + 16'd1;
         if ((w_acc && w_av_oob) || (w_host_acc && w_host_oob)) r_err_oob <= 1'b1;
         // Data is captured at accept so later writes cannot leak into an in-flight read.
         r_pipe_vld[0] <= w_rd_acc;
         if (w_rd_acc) r_pipe_dat[0] <= w_rd_line;
         for (int k = 1; k < READ_LAT; k++) begin
            r_pipe_vld[k] <= r_pipe_vld[k-1];
            if (r_pipe_vld[k-1]) r_pipe_dat[k] <= r_pipe_dat[k-1];
         end
      end
   end

   assign avs_s0_readdata      = r_pipe_dat[READ_LAT-1];
   assign avs_s0_readdatavalid = r_pipe_vld[READ_LAT-1];
   assign err_oob              = r_err_oob;
   assign rd_count             = r_rd_count;
   assign wr_count             = r_wr_count;

endmodule

// File: tb/tb_rsa_mem_slave.sv
// Directed bench for rsa_mem_slave: line-level memory model, expected read queue
// checked every cycle, and literal expectations for the key scenarios.
module tb_rsa_mem_slave;

   localparam int DEPTH       = 40;
   localparam int WAIT_CYCLES = 3;
   localparam int READ_LAT    = 2;

   localparam logic [255:0] L0_EXP = 256'h00000007_00000006_00000005_00000004_00000003_00000002_00000001_00000000;
   localparam logic [255:0] A5_LINE = {32{8'hA5}};
   localparam logic [255:0] L1_EXP = 256'h10000007_10000006_10000005_10000004_10000003_10000002_DEADBEEF_10000000;
   localparam logic [255:0] L3_EXP = 256'h33333333_33333333_33333333_33333333_33333333_33333333_33333333_12345678;

   logic         clk, reset;
   logic [31:0]  avs_s0_address;
   logic         avs_s0_read, avs_s0_write;
   logic [255:0] avs_s0_writedata;
   logic         avs_s0_waitrequest;
   logic [255:0] avs_s0_readdata;
   logic         avs_s0_readdatavalid;
   logic         host_wr_valid, host_wr_ready;
   logic [15:0]  host_wr_addr;
   logic [31:0]  host_wr_data;
   logic         err_oob;
   logic [15:0]  rd_count, wr_count;

   rsa_mem_slave #(.DEPTH(DEPTH), .WAIT_CYCLES(WAIT_CYCLES), .READ_LAT(READ_LAT)) dut (
      .clk                  (clk),
      .reset                (reset),
      .avs_s0_address       (avs_s0_address),
      .avs_s0_read          (avs_s0_read),
      .avs_s0_write         (avs_s0_write),
      .avs_s0_writedata     (avs_s0_writedata),
      .avs_s0_waitrequest   (avs_s0_waitrequest),
      .avs_s0_readdata      (avs_s0_readdata),
      .avs_s0_readdatavalid (avs_s0_readdatavalid),
      .host_wr_valid        (host_wr_valid),
      .host_wr_ready        (host_wr_ready),
      .host_wr_addr         (host_wr_addr),
      .host_wr_data         (host_wr_data),
      .err_oob              (err_oob),
      .rd_count             (rd_count),
      .wr_count             (wr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_checks = 0;
   int n_fail   = 0;

   logic [255:0] m_mem [DEPTH];
   logic [15:0]  m_rd = 16'd0, m_wr = 16'd0;
   logic         m_err = 1'b0;
   logic [255:0] exp_q[$];
   int           due_q[$];
   logic [255:0] last_rd = '0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Read-return checker: a pulse exactly when a read is due, silence otherwise.
   always @(negedge clk) begin
      if (due_q.size() > 0 && due_q[0] == cyc) begin
         chk("rdv_pulse", 256'(avs_s0_readdatavalid), 256'd1);
         chk("rdata", avs_s0_readdata, exp_q[0]);
         last_rd = avs_s0_readdata;
         void'(exp_q.pop_front());
         void'(due_q.pop_front());
      end else begin
         chk("rdv_idle", 256'(avs_s0_readdatavalid), 256'd0);
      end
   end

   task automatic av_cmd(input logic rd, input logic wr, input logic [31:0] addr, input logic [255:0] wd);
      int stalls;
      logic [26:0] line;
      stalls = 0;
      @(posedge clk); #1;
      avs_s0_read = rd; avs_s0_write = wr; avs_s0_address = addr; avs_s0_writedata = wd;
      forever begin
         @(negedge clk);
         if (!avs_s0_waitrequest) break;
         stalls++;
         if (stalls > 50) break;
      end
      chk("stall_cycles", 256'(stalls), 256'(WAIT_CYCLES));
      line = addr[31:5];
      if (rd) begin
         if (line < DEPTH) exp_q.push_back(m_mem[int'(line)]);
         else begin exp_q.push_back('0); m_err = 1'b1; end
         due_q.push_back(cyc + READ_LAT);
         m_rd++;
      end else if (wr) begin
         if (line < DEPTH) m_mem[int'(line)] = wd;
         else m_err = 1'b1;
         m_wr++;
      end
      @(posedge clk); #1;
      avs_s0_read = 1'b0; avs_s0_write = 1'b0;
   endtask

   task automatic host_wr(input logic [15:0] addr, input logic [31:0] data, output int waits);
      int line;
      @(posedge clk); #1;
      host_wr_valid = 1'b1; host_wr_addr = addr; host_wr_data = data;
      waits = 0;
      forever begin
         @(negedge clk);
         if (host_wr_ready) break;
         waits++;
         if (waits > 50) break;
      end
      line = int'(addr) / 8;
      if (line < DEPTH) m_mem[line][(int'(addr) % 8) * 32 +: 32] = data;
      else m_err = 1'b1;
      @(posedge clk); #1;
      host_wr_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (due_q.size() > 0 && n < 20) begin
         @(posedge clk);
         n++;
      end
      chk("drain_timeout", 256'(due_q.size()), 256'd0);
   endtask

   task automatic check_regs(input string tag);
      @(negedge clk);
      chk({tag, "_rd_count"}, 256'(rd_count), 256'(m_rd));
      chk({tag, "_wr_count"}, 256'(wr_count), 256'(m_wr));
      chk({tag, "_err_oob"}, 256'(err_oob), 256'(m_err));
   endtask

   initial begin
      int hw;
      reset = 1'b0;
      avs_s0_address = '0; avs_s0_read = 1'b0; avs_s0_write = 1'b0; avs_s0_writedata = '0;
      host_wr_valid = 1'b0; host_wr_addr = '0; host_wr_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_waitrequest", 256'(avs_s0_waitrequest), 256'd0);
      chk("rst_readdata", avs_s0_readdata, 256'd0);
      chk("rst_host_ready", 256'(host_wr_ready), 256'd1);
      chk("rst_err", 256'(err_oob), 256'd0);
      chk("rst_counts", 256'({rd_count, wr_count}), 256'd0);
      @(posedge clk); #1;
      reset = 1'b1;

      // Key line load through the host port, then a timed Avalon read.
      for (int k = 0; k < 8; k++) host_wr(16'(k), 32'(k), hw);
      chk("model_line0", m_mem[0], L0_EXP);
      av_cmd(1'b1, 1'b0, 32'd0, '0);
      drain();
      chk("line0_read", last_rd, L0_EXP);
      check_regs("t1");

      av_cmd(1'b0, 1'b1, 32'd64, A5_LINE);
      av_cmd(1'b1, 1'b0, 32'd64, '0);
      drain();
      chk("line2_read", last_rd, A5_LINE);
      check_regs("t2");

      // Out-of-range read and write.
      av_cmd(1'b1, 1'b0, 32'd1280, '0);
      drain();
      chk("oob_read_zero", last_rd, 256'd0);
      chk("oob_err_set", 256'(err_oob), 256'd1);
      av_cmd(1'b0, 1'b1, 32'd2048, {256{1'b1}});
      av_cmd(1'b1, 1'b0, 32'd0, '0);
      drain();
      chk("oob_wr_line0", last_rd, L0_EXP);
      av_cmd(1'b1, 1'b0, 32'd64, '0);
      drain();
      chk("oob_wr_line2", last_rd, A5_LINE);
      check_regs("t3");

      // Lane-only host update.
      for (int k = 8; k < 16; k++) host_wr(16'(k), 32'h1000_0000 + 32'(k - 8), hw);
      host_wr(16'd9, 32'hDEADBEEF, hw);
      av_cmd(1'b1, 1'b0, 32'd32, '0);
      drain();
      chk("line1_lane", last_rd, L1_EXP);

      // Host write colliding with an Avalon write accept cycle.
      fork
         av_cmd(1'b0, 1'b1, 32'd96, {8{32'h33333333}});
         begin
            repeat (WAIT_CYCLES) @(posedge clk);
            host_wr(16'd24, 32'h12345678, hw);
         end
      join
      chk("host_blocked_cycles", 256'(hw), 256'd1);
      av_cmd(1'b1, 1'b0, 32'd96, '0);
      drain();
      chk("line3_merge", last_rd, L3_EXP);

      // Read wins over a simultaneous write.
      av_cmd(1'b1, 1'b1, 32'd64, 256'd0);
      drain();
      chk("prio_read", last_rd, A5_LINE);
      av_cmd(1'b1, 1'b0, 32'd64, '0);
      drain();
      chk("prio_no_write", last_rd, A5_LINE);
      check_regs("t5");

      // Master drops the request mid-stall: nothing accepted.
      @(posedge clk); #1;
      avs_s0_read = 1'b1; avs_s0_address = 32'd0;
      @(negedge clk); @(negedge clk);
      @(posedge clk); #1;
      avs_s0_read = 1'b0;
      repeat (5) @(posedge clk);
      check_regs("t_drop");

      // Reset one cycle after a read accept cancels the return.
      av_cmd(1'b1, 1'b0, 32'd0, '0);
      reset = 1'b0;
      exp_q.delete(); due_q.delete();
      m_rd = 16'd0; m_wr = 16'd0; m_err = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      repeat (4) @(posedge clk);
      check_regs("t_rst");
      chk("rst_counts_zero", 256'({rd_count, wr_count, err_oob}), 256'd0);
      av_cmd(1'b1, 1'b0, 32'd0, '0);
      drain();
      chk("post_rst_read", last_rd, L0_EXP);
      check_regs("t_post");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
